// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers.
// Define UART_ARB_FIXED_PRIO_EN to select fixed lowest-index priority instead.
module uart_tx_arbiter #(
  parameter  int NREQ = 4,
  parameter  int DBIT = 8,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DBIT-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 tx_start,
  output logic [DBIT-1:0]      tx_din,
  input  logic                 tx_done_tick,
  output logic [IW-1:0]        grant_id,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t            state_reg, state_next;
  logic [IW-1:0]     last_grant_reg;
  logic [IW-1:0]     grant_id_reg;
  logic [DBIT-1:0]   tx_din_reg;
  logic [DBIT-1:0]   req_bytes [NREQ];
  logic              found;
  logic [IW-1:0]     winner;
  logic [IW-1:0]     cand;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_bytes
      assign req_bytes[gi] = req_data[gi*DBIT +: DBIT];
    end
  endgenerate

  // Winner search; only the selected byte ever reaches tx_din.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IW'(i);
      if (req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
`else
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_grant_reg) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
`endif
  end

  always_comb begin
    req_ready = '0;
    if (state_reg == IDLE && found && !reset)
      req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (found) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (tx_done_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= IW'(NREQ - 1);
      grant_id_reg   <= '0;
      tx_din_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && found) begin
        tx_din_reg     <= req_bytes[winner];
        grant_id_reg   <= winner;
        last_grant_reg <= winner;
      end
    end
  end

  assign tx_start = (state_reg == START);
  assign busy     = (state_reg != IDLE);
  assign tx_din   = tx_din_reg;
  assign grant_id = grant_id_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed requests, queued expected
// grants, and a monitor that checks every tx_start frame.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DBIT = 8;
  localparam int IW   = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 tx_start;
  logic [DBIT-1:0]      tx_din;
  logic                 tx_done_tick;
  logic [IW-1:0]        grant_id;
  logic                 busy;

  logic done_auto = 1'b0;
  logic done_man  = 1'b0;
  logic auto_done = 1'b0;
  logic check_gap = 1'b0;

  assign tx_done_tick = done_auto | done_man;

  int compared   = 0;
  int mismatched = 0;
  int frames_seen = 0;
  logic [15:0] exp_q[$];

  uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input logic [7:0] d);
    exp_q.push_back({8'(id), d});
  endtask

  // Monitor: pops one expected frame per tx_start and checks handshake shape.
  logic prev_start = 1'b0;
  logic done_seen  = 1'b0;
  int   cyc = 0;
  int   done_cyc = 0;
  always @(negedge clk) begin
    logic [15:0] e;
    cyc++;
    if (reset) begin
      prev_start = 1'b0;
      done_seen  = 1'b0;
    end else begin
      if (req_ready != '0) begin
        check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        if (check_gap && done_seen)
          check("idle_gap", cyc - done_cyc, 32'd1);
        done_seen = 1'b0;
      end
      if (!check_gap) done_seen = 1'b0;
      if (tx_done_tick && busy) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      if (tx_start) begin
        frames_seen++;
        check("start_one_cycle", 32'(prev_start), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("frame %0d: grant_id=%0d tx_din=%h (expected %0d/%h)",
                   frames_seen, grant_id, tx_din, e[15:8], e[7:0]);
          check("tx_din", 32'(tx_din), 32'(e[7:0]));
          check("grant_id", 32'(grant_id), 32'(e[15:8]));
          check("busy_in_start", 32'(busy), 32'd1);
        end
      end
      prev_start = tx_start;
    end
  end

  // TX model: done pulse 10 cycles after each start when enabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (auto_done && tx_start) begin
        repeat (10) @(posedge clk);
        #1 done_auto = 1'b1;
        @(posedge clk);
        #1 done_auto = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_frames(input logic [NREQ-1:0] v, input int n);
    int base;
    base = frames_seen;
    req_valid = v;
    for (int i = 0; i < n * 40 && frames_seen < base + n; i++) @(negedge clk);
    #1;
    check("frame_count", frames_seen - base, n);
    req_valid = '0;
    wait_idle();
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 4'b1111;
    req_data = '0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_din", 32'(tx_din), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    req_valid = '0;
    @(posedge clk); #1 reset = 1'b0;

    // Single requester 0, other bytes undriven.
    auto_done = 1'b1;
    req_data = 32'hxxxx_xxA5;
    push(0, 8'hA5);
    req_valid = 4'b0001;
    @(negedge clk);
    check("t1_ready_same_cycle", 32'(req_ready), 32'h1);
    run_frames(4'b0001, 1);

    // All four valid continuously.
    do_reset();
    repeat (2) @(negedge clk);
    check_gap = 1'b1;
    req_data = 32'h1312_1110;
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 5; i++) push(0, 8'h10);
`else
    push(0, 8'h10); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13); push(0, 8'h10);
`endif
    run_frames(4'b1111, 5);
    check_gap = 1'b0;
    repeat (2) @(negedge clk);

    // Requester 2 alone, back to back.
    check_gap = 1'b1;
    req_data = 32'h0077_0000;
    for (int i = 0; i < 3; i++) push(2, 8'h77);
    run_frames(4'b0100, 3);
    check_gap = 1'b0;

    // Stray done ticks in IDLE and START must be ignored.
    auto_done = 1'b0;
    @(posedge clk); #1 done_man = 1'b1;
    @(posedge clk); #1 done_man = 1'b0;
    req_data = 32'h0000_5A00;
    push(1, 8'h5A);
    req_valid = 4'b0010;
    @(posedge clk); #1;
    req_valid = '0;
    done_man = 1'b1;
    @(posedge clk); #1 done_man = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t4_wait_holds", 32'(busy), 32'd1);
    check("t4_tx_din_hold", 32'(tx_din), 32'h5A);
    @(posedge clk); #1 done_man = 1'b1;
    @(posedge clk); #1 done_man = 1'b0;
    @(negedge clk);
    check("t4_done_releases", 32'(busy), 32'd0);

    // Reset while waiting on requester 3's frame.
    req_data = 32'h3C00_0000;
    push(3, 8'h3C);
    req_valid = 4'b1000;
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    check("t5_grant3_in_wait", 32'(grant_id), 32'd3);
    check("t5_busy_in_wait", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_busy_async", 32'(busy), 32'd0);
    check("t5_start_async", 32'(tx_start), 32'd0);
    check("t5_grant_async", 32'(grant_id), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    auto_done = 1'b1;
    req_data = 32'h3D00_000C;
    push(0, 8'h0C);
    run_frames(4'b1001, 1);

    // Requesters 1 and 3 competing.
    req_data = 32'h2300_2100;
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) push(1, 8'h21);
`else
    push(1, 8'h21); push(3, 8'h23); push(1, 8'h21); push(3, 8'h23);
`endif
    run_frames(4'b1010, 4);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared=%0d", compared);
    $fatal(1, "watchdog expired");
  end

endmodule
